// File: rtl/row_scan_pkg.sv
// Shared definitions for the row scan sequencer: state encoding and row geometry.
package row_scan_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NUM_ROWS = 8;
  localparam int unsigned ROW_AW   = 3;
  localparam int unsigned DWELL_W  = 8;

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(NUM_ROWS - 1);
endpackage

// File: rtl/dwell_counter.sv
// Saturating per-row dwell counter; o_term flags that the row has been held DWELL cycles.
module dwell_counter
  import row_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);
  localparam logic [DWELL_W-1:0] TERM_CNT = DWELL_W'(DWELL - 1);

  logic [DWELL_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)             r_cnt <= '0;
    else if (i_clr)           r_cnt <= '0;
    else if (i_en && !o_term) r_cnt <= r_cnt + 1'b1;
  end

  assign o_term = (r_cnt == TERM_CNT);
endmodule

// File: rtl/row_scan_sequencer.sv
// Steps a 3-bit row address 0..7 into the row decoder, one row per acknowledged dwell.
// Build option ROW_SCAN_DWELL_EN: when defined, each row is held at least DWELL cycles.
module row_scan_sequencer
  import row_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic              row_ack,
  output logic [ROW_AW-1:0] row_addr,
  output logic              row_valid,
  output logic              busy,
  output logic              done
);
  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("row_scan_sequencer: DWELL must be 1..255");
  end

  state_t            r_state;
  state_t            w_nxt_state;
  logic [ROW_AW-1:0] r_row_addr;
  logic [ROW_AW-1:0] w_nxt_row;
  logic              r_row_valid;
  logic              r_busy;
  logic              r_done;
  logic              w_term;
  logic              w_adv;

`ifdef ROW_SCAN_DWELL_EN
  logic w_clr;
  logic w_en;

  // Counter sits at zero outside SCAN and restarts on every row change.
  assign w_clr = (r_state != SCAN) || w_adv;
  assign w_en  = (r_state == SCAN);

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .i_clk   (CLOCK_50),
    .i_rst_n (resetn),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_term  (w_term)
  );
`else
  assign w_term = 1'b1;
`endif

  assign w_adv = w_term && row_ack;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_row   = r_row_addr;
    case (r_state)
      IDLE: begin
        w_nxt_row = '0;
        if (start && !abort) w_nxt_state = SCAN;
      end
      SCAN: begin
        // abort outranks an advance landing in the same cycle
        if (abort) begin
          w_nxt_state = IDLE;
          w_nxt_row   = '0;
        end else if (w_adv) begin
          if (r_row_addr == LAST_ROW) w_nxt_state = DONE;
          else                        w_nxt_row   = r_row_addr + 1'b1;
        end
      end
      DONE: begin
        w_nxt_state = IDLE;
        w_nxt_row   = '0;
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_row   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_row_addr  <= '0;
      r_row_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_row_addr  <= w_nxt_row;
      r_row_valid <= (w_nxt_state == SCAN);
      r_busy      <= (w_nxt_state != IDLE);
      r_done      <= (w_nxt_state == DONE);
    end
  end

  assign row_addr  = r_row_addr;
  assign row_valid = r_row_valid;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule

// File: tb/tb_row_scan_sequencer.sv
// Directed bench for row_scan_sequencer; expected timing follows the active build option.
module tb_row_scan_sequencer;
`ifdef ROW_SCAN_DWELL_EN
  localparam int DW = 4;
`else
  localparam int DW = 1;
`endif
  localparam int DONE_EDGE = 8 * DW + 1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       row_ack = 1'b1;
  logic [2:0] row_addr;
  logic       row_valid;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  row_scan_sequencer #(.DWELL(4)) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .start     (start),
    .abort     (abort),
    .row_ack   (row_ack),
    .row_addr  (row_addr),
    .row_valid (row_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_row"},   32'(row_addr),  32'd0);
    chk({tag, "_valid"}, 32'(row_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
  endtask

  // Start pulse then every edge through DONE and back to IDLE, ack held high.
  task automatic full_scan(input string tag);
    row_ack = 1'b1;
    start   = 1'b1;
    for (int k = 1; k <= DONE_EDGE + 1; k++) begin
      step();
      start = 1'b0;
      if (k < DONE_EDGE) begin
        chk({tag, "_row"},   32'(row_addr),  32'((k - 1) / DW));
        chk({tag, "_valid"}, 32'(row_valid), 32'd1);
        chk({tag, "_busy"},  32'(busy),      32'd1);
        chk({tag, "_done"},  32'(done),      32'd0);
      end else if (k == DONE_EDGE) begin
        chk({tag, "_dvalid"}, 32'(row_valid), 32'd0);
        chk({tag, "_dbusy"},  32'(busy),      32'd1);
        chk({tag, "_dpulse"}, 32'(done),      32'd1);
      end else begin
        chk_idle({tag, "_end"});
      end
    end
  endtask

  initial begin
    // reset state
    #12;
    chk_idle("reset");
    resetn = 1'b1;
    step();
    chk_idle("post_reset");

    full_scan("scan1");

    // ack withheld: row 0 held indefinitely
    row_ack = 1'b0;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 19; k++) step();
    chk("hold_row",   32'(row_addr),  32'd0);
    chk("hold_valid", 32'(row_valid), 32'd1);
    row_ack = 1'b1;
    step();
    chk("ack_row1", 32'(row_addr), 32'd1);
    for (int k = 0; k < 6 * DW; k++) step();
    chk("ack_row7", 32'(row_addr), 32'd7);
    for (int k = 0; k < DW; k++) step();
    chk("ack_done", 32'(done), 32'd1);
    step();
    chk_idle("ack_end");

    // abort at row 5, after a mid-scan start that must not restart
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2 * DW; k++) step();
    chk("midstart_pre", 32'(row_addr), 32'd2);
    start = 1'b1;
    for (int k = 0; k < DW; k++) step();
    start = 1'b0;
    chk("midstart_row", 32'(row_addr), 32'd3);
    for (int k = 0; k < 2 * DW; k++) step();
    chk("abort_pre", 32'(row_addr), 32'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort");
    for (int k = 0; k < 4; k++) begin
      step();
      chk("abort_nodone", 32'(done), 32'd0);
    end

    // start together with abort in IDLE does nothing
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk_idle("start_abort");

    // async reset mid-scan at row 3
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3 * DW; k++) step();
    chk("rst_pre", 32'(row_addr), 32'd3);
    #2 resetn = 1'b0;
    #1;
    chk_idle("async_rst");
    step();
    chk_idle("rst_hold");
    #2 resetn = 1'b1;
    full_scan("scan2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
